// File: rtl/peripheral_register_bridge_if.sv
// Host-side request/response channels of the peripheral register bridge.
// Define PERIPHERAL_REGISTER_BRIDGE_WSTRB_EN to add the req_wstrb byte-enable field.
interface peripheral_register_bridge_if;
    // Both channels: a beat transfers on the rising clk edge where valid && ready;
    // the sender holds valid and its payload stable until that edge.
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
`ifdef PERIPHERAL_REGISTER_BRIDGE_WSTRB_EN
    logic [3:0]  req_wstrb;
`endif
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

`ifdef PERIPHERAL_REGISTER_BRIDGE_WSTRB_EN
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
`endif
endinterface

// File: rtl/peripheral_register_bridge.sv
// Single-beat host request to one-hot register strobe bridge, one request in flight.
// Define PERIPHERAL_REGISTER_BRIDGE_WSTRB_EN for byte-enabled (read-modify-write) writes.
module peripheral_register_bridge #(
    parameter int REGS         = 1,
    parameter int ADDRESSWIDTH = (REGS > 1) ? $clog2(REGS) : 1,
    parameter int READ_LATENCY = 0,
    localparam int DEPTH       = 2 ** ADDRESSWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    peripheral_register_bridge_if.slave bus,
    output logic [31:0]              reg_data_in,
    input  logic [32*DEPTH-1:0]      reg_data_out,
    output logic [DEPTH-1:0]         reg_write_en,
    output logic [DEPTH-1:0]         reg_read_en,
    output logic [2:0]               dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STROBE = 3'd1,
        WAIT   = 3'd2,
        WBACK  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_WAIT = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    state_t                  state_q;
    state_t                  state_d;
    logic                    write_q;
    logic                    rmw_q;
    logic [ADDRESSWIDTH-1:0] idx_q;
    logic [2:0]              wait_cnt;
    logic [31:0]             resp_rdata_q;
    logic                    resp_error_q;
    logic [31:0]             data_in_q;

    logic                    accept;
    logic [ADDRESSWIDTH-1:0] req_idx;
    logic                    high_bits_set;
    logic                    req_err;
    logic                    full_word;
    logic                    null_write;
    logic                    sample;
    logic [31:0]             rd_word;
    logic [31:0]             merged;
    logic [DEPTH-1:0]        idx_onehot;

    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign accept         = bus.req_valid && bus.req_ready;

    assign req_idx        = bus.req_addr[ADDRESSWIDTH+1:2];
    assign high_bits_set  = |(bus.req_addr >> (ADDRESSWIDTH + 2));
    assign req_err        = (bus.req_addr[1:0] != 2'b00) || high_bits_set || (int'(req_idx) >= REGS);

    assign rd_word        = reg_data_out[32*idx_q +: 32];
    assign idx_onehot     = DEPTH'(1) << idx_q;

`ifdef PERIPHERAL_REGISTER_BRIDGE_WSTRB_EN
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    assign full_word  = (bus.req_wstrb == 4'hF);
    assign null_write = bus.req_write && (bus.req_wstrb == 4'h0);

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    // Partial byte enables turn a write into a read of the old word followed by a write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rmw_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            rmw_q   <= bus.req_write && !req_err && !full_word && !null_write;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
        end
    end
`else
    assign full_word  = 1'b1;
    assign null_write = 1'b0;
    assign rmw_q      = 1'b0;
    assign merged     = rd_word;
`endif

    // The read word is valid on the last cycle of the latency window: STROBE itself when
    // there is no latency, otherwise the final WAIT cycle.
    assign sample = ((state_q == STROBE) && (!write_q || rmw_q) && (READ_LATENCY == 0)) ||
                    ((state_q == WAIT) && (wait_cnt == LAST_WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err || null_write) state_d = RESP;
                    else                       state_d = STROBE;
                end
            end
            STROBE: begin
                if (write_q && !rmw_q)      state_d = RESP;
                else if (READ_LATENCY == 0) state_d = rmw_q ? WBACK : RESP;
                else                        state_d = WAIT;
            end
            WAIT: begin
                if (wait_cnt == LAST_WAIT) state_d = rmw_q ? WBACK : RESP;
            end
            WBACK: state_d = RESP;
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q      <= 1'b0;
            idx_q        <= '0;
            wait_cnt     <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            data_in_q    <= '0;
        end else begin
            if (accept) begin
                write_q      <= bus.req_write;
                idx_q        <= req_idx;
                resp_rdata_q <= '0;
                resp_error_q <= req_err;
                if (bus.req_write && !req_err && full_word) data_in_q <= bus.req_wdata;
            end
            if (state_q == STROBE)    wait_cnt <= '0;
            else if (state_q == WAIT) wait_cnt <= wait_cnt + 3'd1;
            if (sample) begin
                if (rmw_q) data_in_q    <= merged;
                else       resp_rdata_q <= rd_word;
            end
        end
    end

    always_comb begin
        reg_read_en  = '0;
        reg_write_en = '0;
        if (state_q == STROBE) begin
            if (write_q && !rmw_q) reg_write_en = idx_onehot;
            else                   reg_read_en  = idx_onehot;
        end
        if (state_q == WBACK) reg_write_en = idx_onehot;
    end

    assign reg_data_in    = data_in_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_error = resp_error_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_peripheral_register_bridge.sv
// Directed bench for peripheral_register_bridge (REGS=5, READ_LATENCY=2).
module tb_peripheral_register_bridge;
    localparam int REGS  = 5;
    localparam int RL    = 2;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    peripheral_register_bridge_if bus();
    logic [31:0]         reg_data_in;
    logic [32*DEPTH-1:0] reg_data_out;
    logic [DEPTH-1:0]    reg_write_en;
    logic [DEPTH-1:0]    reg_read_en;
    logic [2:0]          dbg_state;
    logic [31:0]         mem [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
        assign reg_data_out[32*g +: 32] = mem[g];
    end

    peripheral_register_bridge #(.REGS(REGS), .READ_LATENCY(RL)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .reg_data_in  (reg_data_in),
        .reg_data_out (reg_data_out),
        .reg_write_en (reg_write_en),
        .reg_read_en  (reg_read_en),
        .dbg_state    (dbg_state)
    );

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        err;
        logic [31:0] rdata;
        int          ren_cyc;
        int          wen_cyc;
        logic [7:0]  mask;
        logic [31:0] din;
        int          resp_cyc;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic write, input logic [15:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb);
        bus.req_valid = 1'b1;
        bus.req_write = write;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
`ifdef PERIPHERAL_REGISTER_BRIDGE_WSTRB_EN
        bus.req_wstrb = wstrb;
`else
        if (wstrb != 4'hF) $display("note: byte enables ignored in this build");
`endif
    endtask

    // Cycle k counts from the first cycle after acceptance (k=1 is T+1).
    task automatic run_vec(input int n, input vec_t v);
        int          k;
        bit          done;
        logic [31:0] exp_rd;
        @(negedge clk);
        check($sformatf("v%0d req_ready", n), 32'(bus.req_ready), 32'd1);
        drive_req(v.write, v.addr, v.wdata, v.wstrb);
        exp_q.push_back(v.rdata);
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 1;
        done = 1'b0;
        while (!done && k <= 12) begin
            check($sformatf("v%0d read_en k%0d", n, k), 32'(reg_read_en),
                  (k == v.ren_cyc) ? 32'(v.mask) : 32'd0);
            check($sformatf("v%0d write_en k%0d", n, k), 32'(reg_write_en),
                  (k == v.wen_cyc) ? 32'(v.mask) : 32'd0);
            if (k == v.wen_cyc) check($sformatf("v%0d data_in", n), reg_data_in, v.din);
            if (bus.resp_valid) begin
                exp_rd = exp_q.pop_front();
                check($sformatf("v%0d resp_cycle", n), 32'(k), 32'(v.resp_cyc));
                check($sformatf("v%0d rdata", n), bus.resp_rdata, exp_rd);
                check($sformatf("v%0d error", n), 32'(bus.resp_error), 32'(v.err));
                check($sformatf("v%0d data_in_hold", n), reg_data_in, v.din);
                bus.resp_ready = 1'b1;
                done = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d response timeout: got none expected cycle %0d", n, v.resp_cyc);
            if (exp_q.size() > 0) exp_q.delete(0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int exp_k);
        int k;
        k = 0;
        while (!bus.resp_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k), 32'(exp_k));
    endtask

    initial begin
        int k;
        vec_t v;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
`ifdef PERIPHERAL_REGISTER_BRIDGE_WSTRB_EN
        bus.req_wstrb  = 4'hF;
`endif
        mem[0] = 32'h0BAD0000; mem[1] = 32'hAABBCCDD; mem[2] = 32'h22222222; mem[3] = 32'h33333333;
        mem[4] = 32'h12345678; mem[5] = 32'hEEEEEEEE; mem[6] = 32'hEEEEEEEE; mem[7] = 32'hEEEEEEEE;

        //            wr   addr      wdata         wstrb err rdata         ren wen mask    din           resp
        vecs[0]  = '{1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 1, 8'h04, 32'hDEADBEEF, 2};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0,        4'hF, 0, 32'h12345678, 1, 0, 8'h10, 32'hDEADBEEF, 4};
        vecs[2]  = '{1'b0, 16'h0014, 32'h0,        4'hF, 1, 32'h0,        0, 0, 8'h00, 32'hDEADBEEF, 1};
        vecs[3]  = '{1'b0, 16'h0006, 32'h0,        4'hF, 1, 32'h0,        0, 0, 8'h00, 32'hDEADBEEF, 1};
        vecs[4]  = '{1'b1, 16'h0100, 32'h55555555, 4'hF, 1, 32'h0,        0, 0, 8'h00, 32'hDEADBEEF, 1};
        vecs[5]  = '{1'b0, 16'h0000, 32'h0,        4'hF, 0, 32'h0BAD0000, 1, 0, 8'h01, 32'hDEADBEEF, 4};
        vecs[6]  = '{1'b1, 16'h000C, 32'hCAFEF00D, 4'hF, 0, 32'h0,        0, 1, 8'h08, 32'hCAFEF00D, 2};
        vecs[7]  = '{1'b0, 16'h0004, 32'h0,        4'hF, 0, 32'hAABBCCDD, 1, 0, 8'h02, 32'hCAFEF00D, 4};
        vecs[8]  = '{1'b1, 16'h001C, 32'h01234567, 4'hF, 1, 32'h0,        0, 0, 8'h00, 32'hCAFEF00D, 1};
        vecs[9]  = '{1'b0, 16'h8000, 32'h0,        4'hF, 1, 32'h0,        0, 0, 8'h00, 32'hCAFEF00D, 1};
        vecs[10] = '{1'b0, 16'h000C, 32'h0,        4'hF, 0, 32'h33333333, 1, 0, 8'h08, 32'hCAFEF00D, 4};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst resp_error", 32'(bus.resp_error), 32'd0);
        check("rst data_in", reg_data_in, 32'd0);
        check("rst strobes", {16'h0, reg_write_en, reg_read_en}, 32'd0);
        check("rst state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        #1 check("post-rst req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Response back-pressure with the next request already waiting
        @(negedge clk);
        drive_req(1'b0, 16'h0010, 32'h0, 4'hF);
        @(negedge clk);
        check("bp read_en", 32'(reg_read_en), 32'h10);
        bus.req_addr = 16'h000C;
        wait_resp("bp resp_cycle", 3);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold valid %0d", i), 32'(bus.resp_valid), 32'd1);
            check($sformatf("bp hold rdata %0d", i), bus.resp_rdata, 32'h12345678);
            check($sformatf("bp hold error %0d", i), 32'(bus.resp_error), 32'd0);
            check($sformatf("bp req_ready %0d", i), 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        check("bp still valid", 32'(bus.resp_valid), 32'd1);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("bp idle req_ready", 32'(bus.req_ready), 32'd1);
        check("bp idle resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("bp second read_en", 32'(reg_read_en), 32'h08);
        wait_resp("bp second resp_cycle", 3);
        check("bp second rdata", bus.resp_rdata, 32'h33333333);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;

        // Reset while waiting on read latency
        @(negedge clk);
        drive_req(1'b0, 16'h0010, 32'h0, 4'hF);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid read_en", 32'(reg_read_en), 32'h10);
        @(negedge clk);
        check("mid in wait", 32'(dbg_state), 32'd2);
        reset = 1'b1;
        #1;
        check("mid rst strobes", {16'h0, reg_write_en, reg_read_en}, 32'd0);
        check("mid rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid rst req_ready", 32'(bus.req_ready), 32'd0);
        check("mid rst data_in", reg_data_in, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check("mid release req_ready", 32'(bus.req_ready), 32'd1);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid || (reg_read_en != '0) || (reg_write_en != '0)) k++;
        end
        check("mid no activity", 32'(k), 32'd0);

        v = '{1'b1, 16'h0010, 32'h0F0F0F0F, 4'hF, 0, 32'h0, 0, 1, 8'h10, 32'h0F0F0F0F, 2};
        run_vec(11, v);
`ifdef PERIPHERAL_REGISTER_BRIDGE_WSTRB_EN
        v = '{1'b1, 16'h0004, 32'h11223344, 4'b0101, 0, 32'h0, 1, 4, 8'h02, 32'hAA22CC44, 5};
        run_vec(20, v);
        v = '{1'b1, 16'h0008, 32'hFFFFFFFF, 4'b0000, 0, 32'h0, 0, 0, 8'h00, 32'hAA22CC44, 1};
        run_vec(21, v);
        v = '{1'b1, 16'h0008, 32'h99887766, 4'b1000, 1, 32'h0, 0, 0, 8'h00, 32'hAA22CC44, 1};
        v.addr = 16'h0009;
        run_vec(22, v);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/peripheral_register_bridge.md
Name: peripheral_register_bridge

Overview:
Bus-side driver of the peripheral register interface: accepts single-beat read/write requests from a host over a valid/ready channel and decodes the byte address to a word index. It then drives the one-hot write_en/read_en strobes and data_in toward the peripheral's register file, and returns read data or an error on a valid/ready response channel. It sits between the system interconnect and every peripheral core, one instance per peripheral.

Parameters:
REGS, 1, number of implemented 32-bit registers in the peripheral
ADDRESSWIDTH, $clog2(REGS) (minimum 1), word-index width; strobe/data vectors are DEPTH = 2**ADDRESSWIDTH entries
READ_LATENCY, 0, cycles between the read_en strobe and the cycle in which data_out is sampled (0..7)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  host request valid
req_ready  output  1  bridge can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  16  byte address
req_wdata  input  32  write data
resp_valid  output  1  response valid
resp_ready  input  1  host accepts response
resp_rdata  output  32  read data (0 for writes and errors)
resp_error  output  1  decode error
reg_data_in  output  32  write data to peripheral
reg_data_out  input  32*DEPTH  flattened per-register read data, entry i at [32*i+31:32*i]
reg_write_en  output  DEPTH  one-hot write strobe
reg_read_en  output  DEPTH  one-hot read strobe

Behaviour:
- Reset values: req_ready 0 while reset is high; resp_valid 0; resp_rdata 0; resp_error 0; reg_data_in 0; all strobes 0; state IDLE.
- FSM states: IDLE, STROBE, WAIT, RESP. req_ready = (state == IDLE) and not reset.
- Accept at cycle T when req_valid && req_ready. Capture write, addr and wdata.
- Decode: index = req_addr[ADDRESSWIDTH+1:2]. Error if req_addr[1:0] != 0, or any req_addr bit above ADDRESSWIDTH+1 is set, or index >= REGS.
- Error path: IDLE -> RESP. resp_valid at T+1 with resp_error=1 and rdata=0. No strobe is ever asserted.
- Write: STROBE at T+1 with reg_write_en[index]=1 for exactly one cycle and reg_data_in=wdata. RESP at T+2 with error=0 and rdata=0.
- Read: STROBE at T+1 with reg_read_en[index]=1 for exactly one cycle. WAIT lasts READ_LATENCY cycles. reg_data_out[index] is sampled at the end of cycle T+1+READ_LATENCY. resp_valid at T+2+READ_LATENCY.
- RESP: resp_valid, rdata and error are held stable until resp_ready. The cycle of resp_valid && resp_ready returns to IDLE, so the next accept is possible one cycle later. There is no request pipelining; at most one request is in flight.
- reg_data_in holds its last written value between writes. Strobes are never asserted simultaneously and never for more than one cycle per request.
- Reset mid-operation: all outputs take reset values immediately. A pending response is discarded and no further strobe is issued.

Optional Feature:
PERIPHERAL_REGISTER_BRIDGE_WSTRB_EN
- With the macro: adds input req_wstrb[3:0].
  - wstrb == 4'hF: plain write.
  - wstrb == 0: no strobes, OK response at T+1.
  - Partial wstrb: read-modify-write. read_en strobe, READ_LATENCY wait, merge the selected bytes of wdata into the sampled word, write_en strobe of the merged word in the following cycle, then RESP. read_en side effects are accepted.
- Without the macro: no req_wstrb port, and every write is full-word.

Test Plan:
1. REGS=5, ADDRESSWIDTH=3; write 0x08, data 0xDEADBEEF at T -> reg_write_en=8'b00000100 only in T+1, reg_data_in=0xDEADBEEF, resp_valid T+2, error 0.
2. READ_LATENCY=2; reg_data_out[4]=0x12345678; read 0x10 -> reg_read_en bit4 only in T+1, resp_valid T+4, rdata 0x12345678.
3. Read 0x14 (index 5), read 0x06 (misaligned), write 0x0100 (high bit set) -> no strobes, resp_valid T+1, error 1, rdata 0 in each case.
4. Hold resp_ready low 5 cycles with req_valid high -> response held stable, req_ready 0, second request accepted one cycle after the handshake.
5. Assert reset during WAIT -> strobes and resp_valid 0 immediately, no response after release, req_ready 1 on the first cycle after reset falls.
6. With WSTRB_EN: reg_data_out[1]=0xAABBCCDD; write 0x04, data 0x11223344, wstrb 4'b0101 -> read_en[1], then write_en[1] with reg_data_in 0xAA22CC44, then OK response.
